// File: rtl/uart_tx_sched.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte sources,
// with per-requester frame lock, sent-byte counter and sticky start-timeout flag.
`timescale 1ns/1ps
module uart_tx_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_lock,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              grant_valid,
    output logic [IDW-1:0]    grant_id,
    output logic [15:0]       byte_cnt,
    output logic              err_timeout,
    input  logic              err_clear
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

    state_t          state;
    logic            lock_active;
    logic [IDW-1:0]  owner;
    logic [IDW-1:0]  last;
    logic [TW-1:0]   tout_cnt;
    logic [NREQ-1:0] cand;
    logic [IDW-1:0]  sel;
    logic            sel_found;

    // Scan downward so the nearest requester after 'last' is written last and wins.
    always_comb begin
        cand      = lock_active ? (req_valid & (NREQ'(1) << owner)) : req_valid;
        sel       = '0;
        sel_found = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (cand[(int'(last) + k) % NREQ]) begin
                sel       = IDW'((int'(last) + k) % NREQ);
                sel_found = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            byte_cnt    <= '0;
            err_timeout <= 1'b0;
            lock_active <= 1'b0;
            owner       <= '0;
            last        <= IDW'(NREQ - 1);
            tout_cnt    <= '0;
        end else begin
            req_ready <= '0;
            if (err_clear)
                err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    // A released lock costs one idle cycle before open arbitration.
                    if (lock_active && !req_lock[owner]) begin
                        lock_active <= 1'b0;
                        last        <= owner;
                        grant_valid <= 1'b0;
                    end else if (sel_found) begin
                        tx_data        <= req_data[8*sel +: 8];
                        grant_id       <= sel;
                        grant_valid    <= 1'b1;
                        req_ready[sel] <= 1'b1;
                        tx_start       <= 1'b1;
                        tout_cnt       <= '0;
                        state          <= START;
                    end
                end
                START: begin
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        tout_cnt <= '0;
                        state    <= WAIT_DONE;
                    end else if (tout_cnt == TW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        tx_start    <= 1'b0;
                        lock_active <= 1'b0;
                        last        <= grant_id;
                        grant_valid <= 1'b0;
                        tout_cnt    <= '0;
                        state       <= IDLE;
                    end else begin
                        tout_cnt <= tout_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        byte_cnt <= byte_cnt + 16'd1;
                        state    <= IDLE;
                        if (req_lock[grant_id]) begin
                            lock_active <= 1'b1;
                            owner       <= grant_id;
                        end else begin
                            lock_active <= 1'b0;
                            last        <= grant_id;
                            grant_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a small UART busy model.
`timescale 1ns/1ps
module tb_uart_tx_sched;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 20;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [15:0] byte_cnt;
    logic        err_timeout;
    logic        err_clear;

    int errors = 0;
    int checks = 0;
    bit uart_en = 1'b0;
    int busy_delay = 1;
    int busy_hold = 3;

    uart_tx_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_lock   (req_lock),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .byte_cnt   (byte_cnt),
        .err_timeout(err_timeout),
        .err_clear  (err_clear)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // UART core model: busy rises busy_delay cycles after start is seen, held busy_hold cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (uart_en && tx_start && !tx_busy) begin
                repeat (busy_delay) @(negedge wb_clk_i);
                tx_busy = 1'b1;
                repeat (busy_hold) @(negedge wb_clk_i);
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic wait_grant(input int budget, output int idx, output logic [7:0] data,
                              output logic [1:0] gid, output bit ok);
        ok = 1'b0; idx = -1; data = '0; gid = '0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge wb_clk_i);
            if (|req_ready) begin
                ok = 1'b1;
                data = tx_data;
                gid = grant_id;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
            end
        end
    endtask

    task automatic wait_cnt(input logic [15:0] target, input int budget, output bit ok);
        int c = 0;
        ok = 1'b0;
        while (c < budget && !ok) begin
            if (byte_cnt == target) ok = 1'b1;
            else begin
                @(negedge wb_clk_i);
                c++;
            end
        end
    endtask

    task automatic wait_busy(input logic level, input int budget, output bit ok);
        int c = 0;
        ok = 1'b0;
        while (c < budget && !ok) begin
            if (tx_busy == level) ok = 1'b1;
            else begin
                @(negedge wb_clk_i);
                c++;
            end
        end
    endtask

    task automatic do_reset();
        bit ok;
        req_valid = '0; req_lock = '0; err_clear = 1'b0;
        wait_busy(1'b0, 200, ok);
        wb_rst_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1; req_valid = 4'hF; req_data = 32'hDEADBEEF; req_lock = 4'hF; err_clear = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        checks++;
        if ({tx_start, grant_valid, err_timeout, req_ready} !== 7'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0", {tx_start, grant_valid, err_timeout, req_ready});
        end
        checks++;
        if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++;
        if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", grant_id); end
        checks++;
        if (byte_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_byte_cnt: got %0d expected 0", byte_cnt); end
        req_valid = '0; req_lock = '0;
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
    endtask

    task automatic test_single_byte();
        bit ok;
        do_reset();
        uart_en = 1'b1; busy_delay = 2; busy_hold = 100;
        req_data[7:0] = 8'h0F; req_valid = 4'b0001;
        @(negedge wb_clk_i);
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready: got %b expected 0001", req_ready); end
        checks++;
        if (tx_start !== 1'b1) begin errors++; $display("[TB] FAIL single_start: got %b expected 1", tx_start); end
        checks++;
        if (tx_data !== 8'h0F) begin errors++; $display("[TB] FAIL single_data: got %h expected 0f", tx_data); end
        checks++;
        if (grant_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_gvalid: got %b expected 1", grant_valid); end
        req_valid = '0;
        @(negedge wb_clk_i);
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL single_ready_pulse: got %b expected 0000", req_ready); end
        checks++;
        if (tx_start !== 1'b1) begin errors++; $display("[TB] FAIL single_start_hold: got %b expected 1", tx_start); end
        wait_busy(1'b1, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL single_busy_wait: got timeout expected busy"); end
        @(negedge wb_clk_i);
        checks++;
        if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL single_start_drop: got %b expected 0", tx_start); end
        wait_cnt(16'd1, 300, ok);
        checks++;
        if (byte_cnt !== 16'd1) begin errors++; $display("[TB] FAIL single_byte_cnt: got %0d expected 1", byte_cnt); end
        @(negedge wb_clk_i);
        checks++;
        if (grant_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_gvalid_end: got %b expected 0", grant_valid); end
        checks++;
        if (tx_data !== 8'h0F) begin errors++; $display("[TB] FAIL single_data_stable: got %h expected 0f", tx_data); end
    endtask

    task automatic test_fairness();
        bit ok; int idx; logic [7:0] d; logic [1:0] gid;
        do_reset();
        uart_en = 1'b1; busy_delay = 1; busy_hold = 3;
        req_data = 32'hA3A2A1A0; req_valid = 4'hF;
        for (int g = 0; g < 8; g++) begin
            wait_grant(60, idx, d, gid, ok);
            if (g == 7) req_valid = '0;
            checks++;
            if (!ok || idx != g % 4) begin
                errors++; $display("[TB] FAIL fair_order[%0d]: got %0d expected %0d", g, idx, g % 4);
            end
            checks++;
            if (d !== 8'hA0 + 8'(g % 4) || gid !== 2'(g % 4)) begin
                errors++; $display("[TB] FAIL fair_data[%0d]: got %h/id%0d expected %h/id%0d", g, d, gid, 8'hA0 + 8'(g % 4), g % 4);
            end
        end
        wait_cnt(16'd8, 100, ok);
        checks++;
        if (byte_cnt !== 16'd8) begin errors++; $display("[TB] FAIL fair_byte_cnt: got %0d expected 8", byte_cnt); end
    endtask

    task automatic test_lock();
        bit ok; int idx; logic [7:0] d; logic [1:0] gid;
        int exp_id[5] = '{1, 1, 1, 2, 0};
        logic [7:0] exp_d[5] = '{8'h3D, 8'h3E, 8'h3F, 8'hC2, 8'hC0};
        do_reset();
        uart_en = 1'b1; busy_delay = 1; busy_hold = 3;
        req_data = {8'h00, 8'hC2, 8'h3D, 8'hC0};
        req_lock = 4'b0010; req_valid = 4'b0010;
        for (int g = 0; g < 5; g++) begin
            wait_grant(60, idx, d, gid, ok);
            case (g)
                0: begin req_data[15:8] = 8'h3E; req_valid = 4'b0111; end
                1: req_data[15:8] = 8'h3F;
                2: begin req_valid[1] = 1'b0; req_lock[1] = 1'b0; end
                3: req_valid[2] = 1'b0;
                default: req_valid[0] = 1'b0;
            endcase
            checks++;
            if (!ok || idx != exp_id[g] || d !== exp_d[g]) begin
                errors++; $display("[TB] FAIL lock_grant[%0d]: got id%0d/%h expected id%0d/%h", g, idx, d, exp_id[g], exp_d[g]);
            end
        end
        wait_cnt(16'd5, 100, ok);
        checks++;
        if (byte_cnt !== 16'd5) begin errors++; $display("[TB] FAIL lock_byte_cnt: got %0d expected 5", byte_cnt); end
    endtask

    task automatic test_timeout();
        bit ok; int idx; int cnt; logic [7:0] d; logic [1:0] gid;
        do_reset();
        uart_en = 1'b0;
        req_data[15:0] = 16'h6655; req_valid = 4'b0011;
        wait_grant(20, idx, d, gid, ok);
        req_valid[0] = 1'b0;
        checks++;
        if (!ok || idx != 0) begin errors++; $display("[TB] FAIL to_first_grant: got %0d expected 0", idx); end
        cnt = 0;
        while (tx_start && cnt < 100) begin
            cnt++;
            @(negedge wb_clk_i);
        end
        checks++;
        if (cnt != TIMEOUT) begin errors++; $display("[TB] FAIL to_start_len: got %0d expected %0d", cnt, TIMEOUT); end
        checks++;
        if (err_timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_err_set: got %b expected 1", err_timeout); end
        checks++;
        if (byte_cnt !== 16'd0 || grant_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL to_dropped: got cnt%0d gv%b expected cnt0 gv0", byte_cnt, grant_valid);
        end
        wait_grant(20, idx, d, gid, ok);
        req_valid[1] = 1'b0;
        checks++;
        if (!ok || idx != 1 || d !== 8'h66) begin errors++; $display("[TB] FAIL to_next_grant: got %0d/%h expected 1/66", idx, d); end
        err_clear = 1'b1;
        @(negedge wb_clk_i);
        err_clear = 1'b0;
        checks++;
        if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_err_clear: got %b expected 0", err_timeout); end
        repeat (TIMEOUT - 2) @(negedge wb_clk_i);
        checks++;
        if (tx_start !== 1'b1) begin errors++; $display("[TB] FAIL to_start_before_edge: got %b expected 1", tx_start); end
        err_clear = 1'b1;
        @(negedge wb_clk_i);
        err_clear = 1'b0;
        checks++;
        if (tx_start !== 1'b0 || err_timeout !== 1'b1) begin
            errors++; $display("[TB] FAIL to_set_wins: got start%b err%b expected start0 err1", tx_start, err_timeout);
        end
        uart_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok; int idx; logic [7:0] d; logic [1:0] gid;
        do_reset();
        uart_en = 1'b1; busy_delay = 1; busy_hold = 10;
        req_data = 32'h00BB11AA; req_valid = 4'b0010;
        wait_grant(20, idx, d, gid, ok);
        req_valid = '0;
        wait_cnt(16'd1, 60, ok);
        req_valid = 4'b0010;
        wait_grant(20, idx, d, gid, ok);
        req_valid = '0;
        wait_busy(1'b1, 20, ok);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        checks++;
        if ({tx_start, grant_valid, err_timeout, req_ready} !== 7'b0 || tx_data !== 8'h00 || grant_id !== 2'd0) begin
            errors++; $display("[TB] FAIL mid_reset_outs: got %b data%h id%0d expected all 0",
                               {tx_start, grant_valid, err_timeout, req_ready}, tx_data, grant_id);
        end
        checks++;
        if (byte_cnt !== 16'd0) begin errors++; $display("[TB] FAIL mid_reset_cnt: got %0d expected 0", byte_cnt); end
        wb_rst_i = 1'b0;
        wait_busy(1'b0, 30, ok);
        @(negedge wb_clk_i);
        req_valid = 4'b0101;
        wait_grant(20, idx, d, gid, ok);
        req_valid = '0;
        checks++;
        if (!ok || idx != 0 || d !== 8'hAA) begin errors++; $display("[TB] FAIL mid_first_grant: got %0d/%h expected 0/aa", idx, d); end
        wait_cnt(16'd1, 60, ok);
    endtask

    task automatic test_wrap();
        bit ok; int idx; logic [7:0] d; logic [1:0] gid;
        do_reset();
        uart_en = 1'b1; busy_delay = 1; busy_hold = 3;
        force dut.byte_cnt = 16'hFFFF;
        @(negedge wb_clk_i);
        release dut.byte_cnt;
        @(negedge wb_clk_i);
        req_data[7:0] = 8'h5A; req_valid = 4'b0001;
        wait_grant(20, idx, d, gid, ok);
        req_valid = '0;
        checks++;
        if (byte_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_preload: got %h expected ffff", byte_cnt); end
        wait_cnt(16'h0000, 60, ok);
        @(negedge wb_clk_i);
        checks++;
        if (!ok || byte_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_cnt: got %h expected 0000", byte_cnt); end
    endtask

    initial begin
        wb_rst_i = 1'b1; req_valid = '0; req_data = '0; req_lock = '0; err_clear = 1'b0;
        test_reset();
        test_single_byte();
        test_fairness();
        test_lock();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
